// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM port arbiter.
// State encoding and client-index width helper.
package ram_arb_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   function automatic int idw(int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Client-side bundle of the RAM port arbiter.
// Write/read req-gnt handshakes plus tagged read responses.
interface ram_port_arbiter_if #(
   parameter int NR = 4,
   parameter int AW = 8,
   parameter int DW = 32
);
   import ram_arb_pkg::*;

   localparam int IDW = idw(NR);

   logic [NR-1:0]    wr_req;
   logic [NR*AW-1:0] wr_addr;
   logic [NR*DW-1:0] wr_data;
   logic [NR-1:0]    wr_gnt;
   logic [NR-1:0]    rd_req;
   logic [NR*AW-1:0] rd_addr;
   logic [NR-1:0]    rd_gnt;
   logic             rd_rsp_valid;
   logic [IDW-1:0]   rd_rsp_id;
   logic [DW-1:0]    rd_rsp_data;

   modport master (
      output wr_req, wr_addr, wr_data,
      output rd_req, rd_addr,
      input  wr_gnt, rd_gnt,
      input  rd_rsp_valid, rd_rsp_id, rd_rsp_data
   );

   modport slave (
      input  wr_req, wr_addr, wr_data,
      input  rd_req, rd_addr,
      output wr_gnt, rd_gnt,
      output rd_rsp_valid, rd_rsp_id, rd_rsp_data
   );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with its own rotating pointer.
// Grant is combinational; pointer moves past the winner.
module rr_arbiter
   import ram_arb_pkg::*;
#(
   parameter int NR = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NR-1:0]        req,
   input  logic                 advance,
   output logic [NR-1:0]        gnt,
   output logic [idw(NR)-1:0]   idx
);

   localparam int IDW = idw(NR);
   localparam logic [IDW-1:0] LAST = IDW'(NR - 1);

   logic [IDW-1:0] ptr;
   logic [IDW-1:0] j;
   logic           hit;

   always_comb begin
      gnt = '0;
      idx = '0;
      j   = '0;
      hit = 1'b0;
      for (int k = 0; k < NR; k++) begin
         j = IDW'((int'(ptr) + k) % NR);
         if (!hit && req[j]) begin
            hit = 1'b1;
            idx = j;
         end
      end
      if (advance && hit)
         gnt[idx] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr <= '0;
      else if (advance && hit)
         ptr <= (idx == LAST) ? '0 : idx + IDW'(1);
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one simple dual-port RAM between NR clients.
// Independent RR write/read arbitration plus a clear sweep.
module ram_port_arbiter
   import ram_arb_pkg::*;
#(
   parameter int            NR      = 4,
   parameter int            AW      = 8,
   parameter int            DW      = 32,
   parameter logic [DW-1:0] CLR_VAL = '0
) (
   input  logic          clk,
   input  logic          rst,
   ram_port_arbiter_if.slave cl,
   input  logic          clr_start,
   output logic          busy,
   output logic          clr_done,
   output logic          ram_we,
   output logic [AW-1:0] ram_wr_addr,
   output logic [DW-1:0] ram_wr_data,
   output logic [AW-1:0] ram_rd_addr,
   input  logic [DW-1:0] ram_rd_data
);

   localparam int IDW = idw(NR);
   localparam logic [AW-1:0] LAST = '1;

   state_t         state;
   state_t         state_nx;
   logic [AW-1:0]  cnt;
   logic           arb_en;
   logic [NR-1:0]  wr_gnt;
   logic [NR-1:0]  rd_gnt;
   logic [IDW-1:0] wr_idx;
   logic [IDW-1:0] rd_idx;
   logic           rsp_valid;
   logic [IDW-1:0] rsp_id;

   // rst gates grants so they drop in the same cycle
   assign arb_en = (state == ST_IDLE) && !rst;

   rr_arbiter #(.NR(NR)) u_wr_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (cl.wr_req),
      .advance (arb_en),
      .gnt     (wr_gnt),
      .idx     (wr_idx)
   );

   rr_arbiter #(.NR(NR)) u_rd_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (cl.rd_req),
      .advance (arb_en),
      .gnt     (rd_gnt),
      .idx     (rd_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:  if (clr_start) state_nx = ST_CLEAR;
         ST_CLEAR: if (cnt == LAST) state_nx = ST_IDLE;
         default:  state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         clr_done  <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
      end else begin
         clr_done  <= (state == ST_CLEAR) && (cnt == LAST);
         rsp_valid <= |rd_gnt;
         if (state == ST_CLEAR)
            cnt <= cnt + AW'(1);
         if (|rd_gnt)
            rsp_id <= rd_idx;
      end
   end

   always_comb begin
      busy        = (state == ST_CLEAR);
      ram_we      = 1'b0;
      ram_wr_addr = '0;
      ram_wr_data = '0;
      ram_rd_addr = '0;
      if (state == ST_CLEAR) begin
         ram_we      = 1'b1;
         ram_wr_addr = cnt;
         ram_wr_data = CLR_VAL;
      end else begin
         for (int i = 0; i < NR; i++) begin
            if (wr_gnt[i]) begin
               ram_we      = 1'b1;
               ram_wr_addr = cl.wr_addr[i*AW +: AW];
               ram_wr_data = cl.wr_data[i*DW +: DW];
            end
         end
      end
      for (int i = 0; i < NR; i++)
         if (rd_gnt[i])
            ram_rd_addr = cl.rd_addr[i*AW +: AW];
   end

   assign cl.wr_gnt       = wr_gnt;
   assign cl.rd_gnt       = rd_gnt;
   assign cl.rd_rsp_valid = rsp_valid;
   assign cl.rd_rsp_id    = rsp_id;
   assign cl.rd_rsp_data  = ram_rd_data;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter.
// Bench-owned RAM, abstract arbitration/memory model.
module tb_ram_port_arbiter;
   import ram_arb_pkg::*;

   localparam int NR    = 4;
   localparam int AW    = 4;
   localparam int DW    = 32;
   localparam int DEPTH = 1 << AW;
   localparam logic [DW-1:0] CLR = 32'hC1EA_C1EA;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          clr_start = 1'b0;
   logic          busy;
   logic          clr_done;
   logic          ram_we;
   logic [AW-1:0] ram_wr_addr;
   logic [DW-1:0] ram_wr_data;
   logic [AW-1:0] ram_rd_addr;
   logic [DW-1:0] ram_rd_data = '0;
   logic [DW-1:0] mem [DEPTH] = '{default: '0};

   logic [DW-1:0] shadow [DEPTH];
   int checks = 0;
   int failures = 0;
   int wptr, rptr, ccount, rsp_id;
   int last_wi, last_ri, busy_cnt, done_cnt;
   bit clearing, done_exp, rsp_pend;
   logic [DW-1:0] rsp_data;

   ram_port_arbiter_if #(.NR(NR), .AW(AW), .DW(DW)) cif ();

   ram_port_arbiter #(
      .NR(NR), .AW(AW), .DW(DW), .CLR_VAL(CLR)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cl          (cif),
      .clr_start   (clr_start),
      .busy        (busy),
      .clr_done    (clr_done),
      .ram_we      (ram_we),
      .ram_wr_addr (ram_wr_addr),
      .ram_wr_data (ram_wr_data),
      .ram_rd_addr (ram_rd_addr),
      .ram_rd_data (ram_rd_data)
   );

   always #5 clk = ~clk;

   // external RAM: write commit on edge, registered read returns old data
   always @(posedge clk) begin
      if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
      ram_rd_data <= mem[ram_rd_addr];
   end

   task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int pick(logic [NR-1:0] r, int p);
      for (int k = 0; k < NR; k++)
         if (r[(p + k) % NR]) return (p + k) % NR;
      return -1;
   endfunction

   task automatic wr_set(int i, logic [AW-1:0] a, logic [DW-1:0] d);
      cif.wr_req[i] = 1'b1;
      cif.wr_addr[i*AW +: AW] = a;
      cif.wr_data[i*DW +: DW] = d;
   endtask

   task automatic rd_set(int i, logic [AW-1:0] a);
      cif.rd_req[i] = 1'b1;
      cif.rd_addr[i*AW +: AW] = a;
   endtask

   task automatic cycle();
      logic [NR-1:0] ew, er;
      logic [AW-1:0] wa, ra;
      logic [DW-1:0] wd;
      int wi, ri;
      #1;
      if (rst) begin
         wptr = 0; rptr = 0; ccount = 0; clearing = 0;
         done_exp = 0; rsp_pend = 0; rsp_id = 0;
      end
      ew = '0; er = '0; wi = -1; ri = -1;
      wa = '0; ra = '0; wd = '0;
      if (!rst && !clearing) begin
         wi = pick(cif.wr_req, wptr);
         ri = pick(cif.rd_req, rptr);
      end
      if (wi >= 0) begin
         ew[wi] = 1'b1;
         wa = cif.wr_addr[wi*AW +: AW];
         wd = cif.wr_data[wi*DW +: DW];
      end
      if (ri >= 0) begin
         er[ri] = 1'b1;
         ra = cif.rd_addr[ri*AW +: AW];
      end
      if (busy === 1'b1) busy_cnt++;
      if (clr_done === 1'b1) done_cnt++;
      chk("wr_gnt", cif.wr_gnt, ew);
      chk("rd_gnt", cif.rd_gnt, er);
      chk("busy", busy, clearing);
      chk("clr_done", clr_done, done_exp);
      chk("rsp_valid", cif.rd_rsp_valid, rsp_pend);
      chk("ram_we", ram_we, clearing || wi >= 0);
      if (rsp_pend) begin
         chk("rsp_id", cif.rd_rsp_id, rsp_id);
         chk("rsp_data", cif.rd_rsp_data, rsp_data);
      end
      if (rst) begin
         chk("rst_rsp_id", cif.rd_rsp_id, 0);
         chk("rst_wr_addr", ram_wr_addr, 0);
         chk("rst_wr_data", ram_wr_data, 0);
         chk("rst_rd_addr", ram_rd_addr, 0);
      end else if (clearing) begin
         chk("clr_addr", ram_wr_addr, ccount);
         chk("clr_data", ram_wr_data, CLR);
      end else if (wi >= 0) begin
         chk("wr_addr", ram_wr_addr, wa);
         chk("wr_data", ram_wr_data, wd);
      end
      if (ri >= 0) chk("rd_addr", ram_rd_addr, ra);
      @(posedge clk);
      if (!rst) begin
         done_exp = clearing && (ccount == DEPTH - 1);
         rsp_pend = (ri >= 0);
         if (ri >= 0) begin
            rsp_id = ri;
            rsp_data = shadow[ra];
            rptr = (ri + 1) % NR;
         end
         if (clearing) begin
            shadow[ccount] = CLR;
            ccount = ccount + 1;
            if (ccount == DEPTH) begin
               clearing = 0;
               ccount = 0;
            end
         end else begin
            if (wi >= 0) begin
               shadow[wa] = wd;
               wptr = (wi + 1) % NR;
            end
            if (clr_start) clearing = 1;
         end
      end
      last_wi = wi;
      last_ri = ri;
      @(negedge clk);
   endtask

   initial begin
      cif.wr_req = '0; cif.wr_addr = '0; cif.wr_data = '0;
      cif.rd_req = '0; cif.rd_addr = '0;
      for (int k = 0; k < DEPTH; k++) shadow[k] = '0;
      busy_cnt = 0; done_cnt = 0;

      // reset state
      @(negedge clk);
      cycle();
      cycle();
      rst = 1'b0;

      // all four writers: rotation 0,1,2,3
      for (int i = 0; i < NR; i++) wr_set(i, AW'(i + 1), 32'h1000 + i);
      for (int c = 0; c < NR; c++) begin
         #1 chk("rr_wr_gnt", cif.wr_gnt, 64'(1) << c);
         cycle();
      end
      cif.wr_req = '0;
      for (int i = 0; i < NR; i++) chk("rr_wr_mem", mem[i + 1], 32'h1000 + i);

      // pointer at 1: 1001 grants 3 then 0, pointer back at 1
      wr_set(0, 4'h5, 32'h55);
      cycle();
      cif.wr_req = '0;
      wr_set(0, 4'h6, 32'h66);
      wr_set(3, 4'h7, 32'h77);
      #1 chk("skip_gnt3", cif.wr_gnt, 4'b1000);
      cycle();
      cif.wr_req[3] = 1'b0;
      #1 chk("skip_gnt0", cif.wr_gnt, 4'b0001);
      cycle();
      cif.wr_req = '0;
      wr_set(0, 4'h8, 32'h88);
      wr_set(1, 4'h9, 32'h99);
      #1 chk("skip_ptr1", cif.wr_gnt, 4'b0010);
      cycle();
      cif.wr_req[1] = 1'b0;
      cycle();
      cif.wr_req = '0;

      // read latency
      wr_set(0, 4'hA, 32'hDEAD_BEEF);
      cycle();
      cif.wr_req = '0;
      rd_set(2, 4'hA);
      cycle();
      cif.rd_req = '0;
      #1;
      chk("lat_valid", cif.rd_rsp_valid, 1);
      chk("lat_id", cif.rd_rsp_id, 2);
      chk("lat_data", cif.rd_rsp_data, 32'hDEAD_BEEF);
      cycle();

      // same-address write+read returns old word
      wr_set(1, 4'hC, 32'h3);
      cycle();
      cif.wr_req = '0;
      wr_set(1, 4'hC, 32'h5);
      rd_set(3, 4'hC);
      cycle();
      cif.wr_req = '0;
      cif.rd_req = '0;
      #1 chk("coll_old", cif.rd_rsp_data, 32'h3);
      cycle();
      rd_set(0, 4'hC);
      cycle();
      cif.rd_req = '0;
      #1 chk("coll_new", cif.rd_rsp_data, 32'h5);
      cycle();

      // full clear sweep with requests held and a stray clr_start
      busy_cnt = 0; done_cnt = 0;
      clr_start = 1'b1;
      cycle();
      clr_start = 1'b0;
      cif.wr_req = '1;
      cif.rd_req = '1;
      for (int s = 0; s < DEPTH; s++) begin
         clr_start = (s == 5);
         cycle();
      end
      clr_start = 1'b0;
      cif.wr_req = '0;
      cif.rd_req = '0;
      cycle();
      cycle();
      chk("clr_busy_cycles", busy_cnt, DEPTH);
      chk("clr_done_pulses", done_cnt, 1);
      for (int k = 0; k < DEPTH; k++) chk("clr_mem", mem[k], CLR);

      // sweep interrupted by reset in sweep cycle 7
      for (int k = 0; k < DEPTH; k++) begin
         wr_set(k % NR, AW'(k), 32'h100 + k);
         cycle();
         cif.wr_req = '0;
      end
      busy_cnt = 0; done_cnt = 0;
      clr_start = 1'b1;
      cycle();
      clr_start = 1'b0;
      wr_set(2, 4'h3, 32'h999);
      for (int s = 0; s < 7; s++) cycle();
      rd_set(1, 4'h2);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      cif.wr_req = '0;
      cif.rd_req = '0;
      cycle();
      cycle();
      chk("rst_busy_cycles", busy_cnt, 7);
      chk("rst_no_done", done_cnt, 0);
      for (int k = 0; k < DEPTH; k++)
         chk("rst_mem", mem[k], (k < 7) ? CLR : 32'h100 + k);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NR; i++) begin
            if (!cif.wr_req[i] && $urandom_range(0, 1) == 1)
               wr_set(i, AW'($urandom), $urandom);
            if (!cif.rd_req[i] && $urandom_range(0, 1) == 1)
               rd_set(i, AW'($urandom));
         end
         clr_start = ($urandom_range(0, 39) == 0);
         rst = (n == 200);
         cycle();
         rst = 1'b0;
         clr_start = 1'b0;
         if (last_wi >= 0) cif.wr_req[last_wi] = 1'b0;
         if (last_ri >= 0) cif.rd_req[last_ri] = 1'b0;
      end
      cif.wr_req = '0;
      cif.rd_req = '0;
      for (int s = 0; s < DEPTH + 2; s++) cycle();
      for (int k = 0; k < DEPTH; k++) chk("final_mem", mem[k], shadow[k]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
